// File: rtl/rotate_pkg.sv
// Shared definitions for the rotating-pattern sequencer and the barrel-shifter
// top that consumes its outputs.
//   rot_state_t  : sequencer FSM states
//   ROT_W        : default pattern width
//   ROT_TICK_DIV : default clock cycles per automatic step
package rotate_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE
    } rot_state_t;

    localparam int ROT_W        = 8;
    localparam int ROT_TICK_DIV = 50_000_000;

endpackage

// File: rtl/rotate_sequencer_tick_prescaler.sv
// tick_prescaler: modulo-TICK_DIV cycle counter that paces automatic steps.
// Ports:
//   clk   in  : clock
//   srst  in  : synchronous active-high reset, clears the count
//   clr   in  : clear the count to 0 (takes precedence over en)
//   en    in  : count this cycle; when not set the count is held
//   tick  out : high in the cycle where an enabled count wraps from
//               TICK_DIV-1 back to 0 (combinational, consumed by the FSM)
module tick_prescaler #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic srst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    // At least one bit so TICK_DIV=1 still yields a legal register.
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt_reg;
    logic [PW-1:0] cnt_next;

    assign tick = en && (cnt_reg == LAST);

    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (en) begin
            cnt_next = (cnt_reg == LAST) ? '0 : cnt_reg + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/rotate_sequencer.sv
// rotate_sequencer: latches a pattern and rotate direction and steps the
// rotate amount for a downstream combinational barrel shifter, either on a
// programmable tick (RUN) or by single steps (PAUSE).
// Ports:
//   clk        in       : clock, all logic on rising edge
//   reset      in       : synchronous active-high reset
//   load       in       : capture pattern_in/dir_in, zero amount, go IDLE
//   pattern_in in  [W]  : pattern to rotate
//   dir_in     in       : 1 = rotate left, 0 = rotate right
//   start      in       : begin (from IDLE) or resume (from PAUSE) stepping
//   stop       in       : pause stepping
//   step       in       : advance one position, PAUSE only
//   shift_in   out [W]  : latched pattern
//   shift_amt  out [AMT_W] : current rotate amount
//   shift_lr   out      : latched direction
//   running    out      : high while in RUN
//   wrap       out      : one-cycle pulse after shift_amt advances W-1 -> 0
module rotate_sequencer
    import rotate_pkg::*;
#(
    parameter int W        = ROT_W,
    parameter int TICK_DIV = ROT_TICK_DIV,
    localparam int AMT_W   = $clog2(W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [W-1:0]     pattern_in,
    input  logic             dir_in,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    output logic [W-1:0]     shift_in,
    output logic [AMT_W-1:0] shift_amt,
    output logic             shift_lr,
    output logic             running,
    output logic             wrap
);

    localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(W - 1);

    rot_state_t       state_reg, state_next;
    logic [AMT_W-1:0] amt_reg, amt_next;
    logic [W-1:0]     pattern_reg;
    logic             lr_reg;
    logic             wrap_reg, wrap_next;
    logic             pre_clr;
    logic             pre_en;
    logic             tick;
    logic             advance;

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk (clk),
        .srst(reset),
        .clr (pre_clr),
        .en  (pre_en),
        .tick(tick)
    );

    // Exactly one action per edge, in priority order load > stop > start >
    // step/tick. stop consumes the edge in every state, so it also masks a
    // simultaneous start or step. start in RUN has nothing to do and lets
    // the tick proceed so a held start does not stall the animation.
    always_comb begin
        state_next = state_reg;
        amt_next   = amt_reg;
        wrap_next  = 1'b0;
        pre_clr    = 1'b0;
        pre_en     = 1'b0;
        advance    = 1'b0;

        if (load) begin
            state_next = IDLE;
            amt_next   = '0;
            pre_clr    = 1'b1;
        end else if (stop) begin
            // Prescaler not enabled: its phase is kept for the resume.
            if (state_reg == RUN) begin
                state_next = PAUSE;
            end
        end else if (start && (state_reg != RUN)) begin
            state_next = RUN;
            // Fresh start restarts the period; resume from PAUSE keeps phase.
            if (state_reg == IDLE) begin
                pre_clr = 1'b1;
            end
        end else begin
            case (state_reg)
                RUN: begin
                    pre_en  = 1'b1;
                    advance = tick;
                end
                PAUSE: advance = step;
                default: ;
            endcase
        end

        if (advance) begin
            amt_next  = amt_reg + AMT_W'(1);
            wrap_next = (amt_reg == AMT_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            amt_reg     <= '0;
            pattern_reg <= '0;
            lr_reg      <= 1'b0;
            wrap_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            amt_reg   <= amt_next;
            wrap_reg  <= wrap_next;
            if (load) begin
                pattern_reg <= pattern_in;
                lr_reg      <= dir_in;
            end
        end
    end

    assign shift_in  = pattern_reg;
    assign shift_amt = amt_reg;
    assign shift_lr  = lr_reg;
    assign running   = (state_reg == RUN);
    assign wrap      = wrap_reg;

endmodule

// File: tb/tb_rotate_sequencer.sv
// Directed bench for rotate_sequencer with W=8, TICK_DIV=4.
// Inputs change 1 ns after a rising edge; outputs are checked 1 ns after the
// following edge, so each cyc() call corresponds to one sampled edge.
module tb_rotate_sequencer;

    localparam int W        = 8;
    localparam int TICK_DIV = 4;
    localparam int AMT_W    = 3;

    logic             clk;
    logic             reset;
    logic             load;
    logic [W-1:0]     pattern_in;
    logic             dir_in;
    logic             start;
    logic             stop;
    logic             step;
    logic [W-1:0]     shift_in;
    logic [AMT_W-1:0] shift_amt;
    logic             shift_lr;
    logic             running;
    logic             wrap;

    int checks = 0;
    int errors = 0;

    rotate_sequencer #(
        .W       (W),
        .TICK_DIV(TICK_DIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .pattern_in(pattern_in),
        .dir_in    (dir_in),
        .start     (start),
        .stop      (stop),
        .step      (step),
        .shift_in  (shift_in),
        .shift_amt (shift_amt),
        .shift_lr  (shift_lr),
        .running   (running),
        .wrap      (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; pattern_in = '0; dir_in = 1'b0;
        start = 1'b0; stop = 1'b0; step = 1'b0;
        cyc(); cyc();
        reset = 1'b0;

        // Idle after reset: everything quiet for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            cyc();
            check("idle_amt", 32'(shift_amt), 0);
            check("idle_in", 32'(shift_in), 0);
            check("idle_run", 32'(running), 0);
            check("idle_wrap", 32'(wrap), 0);
        end
        $display("reset/idle: 20 cycles checked");

        // Load 0x81 rotating left.
        pattern_in = 8'h81; dir_in = 1'b1; load = 1'b1;
        cyc();
        load = 1'b0; pattern_in = 8'h00; dir_in = 1'b0;
        check("load_in", 32'(shift_in), 32'h81);
        check("load_lr", 32'(shift_lr), 1);
        check("load_amt", 32'(shift_amt), 0);
        check("load_run", 32'(running), 0);
        $display("load 0x81 dir=1: in=%0h lr=%0b", shift_in, shift_lr);

        // Start at edge k, then watch 34 edges: increment every 4, wrap at k+32.
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("start_run", 32'(running), 1);
        check("start_amt", 32'(shift_amt), 0);
        for (int n = 1; n <= 34; n++) begin
            cyc();
            check("run_amt", 32'(shift_amt), 32'((n / 4) % 8));
            check("run_wrap", 32'(wrap), (n == 32) ? 1 : 0);
            check("run_lr", 32'(shift_lr), 1);
        end
        $display("run: 34 edges after start, amt=%0d", shift_amt);

        // Prescaler now sits 2 cycles into a period; stop and hold 10 cycles.
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check("stop_run", 32'(running), 0);
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("pause_amt", 32'(shift_amt), 0);
            check("pause_run", 32'(running), 0);
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("resume_run", 32'(running), 1);
        check("resume_amt0", 32'(shift_amt), 0);
        cyc();
        check("resume_amt1", 32'(shift_amt), 0);
        cyc();
        check("resume_amt2", 32'(shift_amt), 1);
        $display("resume: increment 2 RUN cycles after start, amt=%0d", shift_amt);

        // Pause again and single-step 7 times: 1 -> 0 with a wrap on the last.
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check("stop2_run", 32'(running), 0);
        for (int i = 1; i <= 7; i++) begin
            step = 1'b1;
            cyc();
            step = 1'b0;
            check("step_amt", 32'(shift_amt), 32'((1 + i) % 8));
            check("step_wrap", 32'(wrap), (i == 7) ? 1 : 0);
            cyc();
            check("step_hold", 32'(shift_amt), 32'((1 + i) % 8));
            check("step_wrap_off", 32'(wrap), 0);
            $display("step %0d: amt=%0d", i, shift_amt);
        end

        // Resume (prescaler phase 0) and pulse step while running: ignored.
        start = 1'b1;
        cyc();
        start = 1'b0;
        step = 1'b1;
        cyc();
        step = 1'b0;
        check("run_step_amt", 32'(shift_amt), 0);
        cyc();
        check("run_step_amt2", 32'(shift_amt), 0);

        // load + start on the same edge in RUN: load wins.
        pattern_in = 8'h0F; dir_in = 1'b0; load = 1'b1; start = 1'b1;
        cyc();
        load = 1'b0; start = 1'b0; pattern_in = 8'h00;
        check("ldst_run", 32'(running), 0);
        check("ldst_amt", 32'(shift_amt), 0);
        check("ldst_in", 32'(shift_in), 32'h0F);
        check("ldst_lr", 32'(shift_lr), 0);
        $display("load+start in RUN: in=%0h running=%0b", shift_in, running);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("ldst_idle_amt", 32'(shift_amt), 0);
        end

        // start + stop together in IDLE: stays IDLE; step in IDLE ignored.
        start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        check("ss_run", 32'(running), 0);
        for (int i = 0; i < 6; i++) begin
            cyc();
            check("ss_amt", 32'(shift_amt), 0);
        end
        step = 1'b1;
        cyc();
        step = 1'b0;
        check("idle_step_amt", 32'(shift_amt), 0);
        $display("start+stop/step in IDLE: running=%0b amt=%0d", running, shift_amt);

        // Fresh start from IDLE, first increment exactly 4 edges later.
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            cyc();
            check("restart_amt", 32'(shift_amt), (n == 4) ? 1 : 0);
        end

        // Reset mid-RUN returns all outputs to reset values.
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("rst_in", 32'(shift_in), 0);
        check("rst_amt", 32'(shift_amt), 0);
        check("rst_lr", 32'(shift_lr), 0);
        check("rst_run", 32'(running), 0);
        check("rst_wrap", 32'(wrap), 0);
        cyc(); cyc(); cyc(); cyc();
        check("rst_idle_amt", 32'(shift_amt), 0);
        $display("reset mid-RUN: outputs cleared");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rotate_sequencer.md
# rotate_sequencer

Control stage directly upstream of the 8-bit rotate barrel shifter. It latches a pattern and direction, then steps the shift amount on a programmable tick, so the shifter output animates a rotating pattern (e.g. LED chaser). The shifter consumes `shift_in`, `shift_amt` and `shift_lr` unmodified. Start, stop, single-step and reload are supported.

## Interface
- `W`, default 8: pattern width; must be a power of 2, at least 2.
- `TICK_DIV`, default 50_000_000: clock cycles per automatic step; must be at least 1.
- `AMT_W`, default `$clog2(W)`: derived localparam; not overridable.
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `load` in 1: capture `pattern_in` and `dir_in`; accepted in any state.
- `pattern_in` in W: pattern to rotate.
- `dir_in` in 1: 1 = rotate left, 0 = rotate right.
- `start` in 1: begin or resume automatic stepping.
- `stop` in 1: pause automatic stepping.
- `step` in 1: advance one position; honoured only in PAUSE.
- `shift_in` out W: latched pattern, to shifter `in`.
- `shift_amt` out AMT_W: current rotate amount, to shifter `amt`.
- `shift_lr` out 1: latched direction, to shifter `lr`.
- `running` out 1: 1 while in RUN.
- `wrap` out 1: one-cycle pulse when `shift_amt` advances from W-1 to 0.

## Operation
- States:
  - IDLE: `shift_amt` held at 0.
  - RUN: automatic stepping.
  - PAUSE: `shift_amt` frozen; `step` allowed.
- Per-edge priority: `reset` > `load` > `stop` > `start` > `step`/tick. Exactly one action is taken per edge.
- `reset`: state IDLE, `shift_in`=0, `shift_amt`=0, `shift_lr`=0, prescaler=0, `running`=0, `wrap`=0.
- `load` (any state): `shift_in`<=`pattern_in`, `shift_lr`<=`dir_in`, `shift_amt`<=0, prescaler<=0, state<=IDLE. Any other input on the same edge is ignored.
- `stop`:
  - RUN → PAUSE, prescaler value retained.
  - In IDLE or PAUSE: no effect. It still blocks `start` on the same edge.
- `start`:
  - IDLE → RUN, prescaler<=0.
  - PAUSE → RUN, prescaler resumes from its retained value.
  - In RUN: no effect.
- Tick (RUN only):
  - If prescaler == TICK_DIV-1: prescaler<=0 and `shift_amt`<=`shift_amt`+1 mod W.
  - Otherwise: prescaler increments.
- `step` in PAUSE: `shift_amt`<=`shift_amt`+1 mod W; prescaler unchanged. `step` in IDLE or RUN is ignored.
- Arithmetic:
  - `shift_amt` is AMT_W bits; wrap-around is natural overflow.
  - Prescaler width is `$clog2(TICK_DIV)` bits, minimum 1.
  - With TICK_DIV=1, RUN advances every cycle.
- `wrap` is asserted on the edge that writes `shift_amt`=0 by a tick or a step. It is not asserted for reset or load.
- `dir_in`, `pattern_in` and `shift_lr` are sampled only on `load`. Direction never changes mid-run.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- `load` sampled at edge k: new `shift_in`/`shift_lr` and `shift_amt`=0 are visible after edge k. The downstream shifter output is valid the same cycle, because the shifter is combinational.
- `start` sampled at edge k from IDLE:
  - `running`=1 after edge k.
  - First increment of `shift_amt` at edge k+TICK_DIV.
  - Subsequent increments every TICK_DIV cycles.
- Stop and resume preserve phase: total RUN cycles between increments is always TICK_DIV.
- `wrap` is high for exactly the cycle following the wrapping edge.
- Reset asserted mid-RUN returns all outputs to reset values after that edge. An in-flight tick is lost.

## Structure
- Package `rotate_pkg`:
  - `typedef enum logic [1:0] {IDLE, RUN, PAUSE} rot_state_t`.
  - Default constants `ROT_W=8` and `ROT_TICK_DIV=50_000_000`, shared with the barrel-shifter top.
- Sub-module `tick_prescaler`: mod-TICK_DIV counter with `clr`, `en` and `tick` output.
- The FSM, pattern/direction registers and amount counter live in `rotate_sequencer`.
- The top level instantiates `rotate_sequencer` feeding the barrel shifter.

## Test plan
All scenarios use W=8 and TICK_DIV=4.
- Reset, then idle: `shift_amt`=0, `shift_in`=0x00, `running`=0, `wrap`=0 for 20 cycles with no inputs.
- `load` 0x81 with `dir_in`=1, then `start` at edge k: `shift_amt` = 1, 2, 3 at edges k+4, k+8, k+12. `shift_lr`=1 throughout.
- Run to 32 cycles after `start`: `shift_amt` goes 7→0 at edge k+32. `wrap` is high for one cycle only.
- `stop` 2 cycles into a period, hold 10 cycles, then `start`: the next increment occurs 2 RUN cycles after resume. Three `step` pulses in PAUSE advance `shift_amt` by exactly 3.
- `load` 0x0F and `start` on the same edge while in RUN: state IDLE, `shift_amt`=0, `shift_in`=0x0F, `running`=0.
- `start` and `stop` together in IDLE: stays IDLE. `step` in IDLE or RUN: `shift_amt` unchanged by the step.
